apb_master_arbiter: RTL

Round-robin arbiter that shares one APB_master instance between NREQ independent command sources. It accepts one command at a time from a requester, issues it to APB_master as a single-cycle i_valid pulse, and waits for the completion strobe. It then routes the read data back to the granted requester. It sits directly in front of APB_master, on the same clock, and drives its i_cmd/i_valid while consuming its o_resp/o_ready.

---
 rtl/apb_master_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB_master between NREQ command sources.
// One command is in flight at a time: IDLE picks a requester, ISSUE pulses
// m_valid for one cycle, WAIT holds until the master's completion strobe,
// and DONE returns the captured read data to the granted requester.
module apb_master_arbiter #(
  parameter  int NREQ = 4,
  parameter  int DW   = 32,
  parameter  int AW   = 32,
  localparam int CW   = 1 + DW + AW,
  localparam int GW   = $clog2(NREQ)
) (
  input  logic                pCLK,
  input  logic                pRESET,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*CW-1:0]  req_cmd,
  output logic [NREQ-1:0]     req_ack,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [DW-1:0]       rsp_data,
  output logic                busy,
  output logic [GW-1:0]       grant_id,
  output logic [CW-1:0]       m_cmd,
  output logic                m_valid,
  input  logic [DW-1:0]       m_resp,
  input  logic                m_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [GW-1:0]   last;      // most recently granted requester
  logic [GW-1:0]   pick;      // round-robin winner for this IDLE cycle
  logic [GW-1:0]   cand;      // candidate index while scanning
  logic            found;
  logic [CW-1:0]   pick_cmd;  // command of the winning requester

  // Round-robin search: start just above the last grant and wrap upward.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = GW'((int'(last) + i) % NREQ);
      if (!found && req_valid[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // Select the winner's command slice with constant offsets only.
  always_comb begin
    pick_cmd = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick == GW'(k)) pick_cmd = req_cmd[k*CW +: CW];
    end
  end

  // Transaction sequencer with registered outputs.
  always_ff @(posedge pCLK) begin
    // NOTE: state and outputs use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (pRESET) begin
      state     <= IDLE;
      last      <= GW'(NREQ - 1);
      grant_id  <= '0;
      m_cmd     <= '0;
      m_valid   <= 1'b0;
      req_ack   <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      // Pulse outputs default low; states below raise them for one cycle.
      m_valid   <= 1'b0;
      req_ack   <= '0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            m_cmd         <= pick_cmd;
            grant_id      <= pick;
            last          <= pick;
            m_valid       <= 1'b1;
            req_ack[pick] <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          // m_ready is deliberately not looked at here.
          state <= WAIT;
        end
        WAIT: begin
          if (m_ready) begin
            rsp_data            <= m_resp;
            rsp_valid[grant_id] <= 1'b1;
            state               <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
